// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline valid/stall controller: stall cause
// encoding, per-stage indices into the squash vectors, and the cause
// priority encoder used by the controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_LOAD_USE = 2'd1,
    CAUSE_MEM_WAIT = 2'd2,
    CAUSE_FLUSH    = 2'd3
  } stall_cause_e;

  // Bit positions inside the per-stage squash vectors
  localparam int unsigned STG_ID     = 0;
  localparam int unsigned STG_EX     = 1;
  localparam int unsigned STG_MEM    = 2;
  localparam int unsigned STG_WB     = 3;
  localparam int unsigned NUM_STAGES = 4;

  // Memory wait dominates everything (the MEM stage physically cannot move),
  // then a flush (squashed work must not be held), then the load-use bubble.
  function automatic stall_cause_e encodeCause(input logic memWait,
                                               input logic flushReq,
                                               input logic loadUse);
    stall_cause_e cause;
    if (memWait)       cause = CAUSE_MEM_WAIT;
    else if (flushReq) cause = CAUSE_FLUSH;
    else if (loadUse)  cause = CAUSE_LOAD_USE;
    else               cause = CAUSE_NONE;
    return cause;
  endfunction

endpackage

// File: rtl/perf_counter.sv
// Free-running wrap-around event counter with asynchronous active-high
// reset. Only compiled when PERF_COUNTERS_EN is defined, since it is used
// solely by the optional performance-counter block of pipe_valid_ctrl.
`ifdef PERF_COUNTERS_EN
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: add one on each event, wrapping naturally at 2^CNT_W
  always_comb begin
    count_d = count_q;
    if (inc) count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign q = count_q;

endmodule
`endif

// File: rtl/pipe_valid_ctrl.sv
// Pipeline valid-bit and enable controller. Consumes the hazard unit's
// stall/flush requests, owns the ID/EX/MEM/WB valid bits and load tags, and
// arbitrates data-memory waits against flushes through a pending-flush
// register so a squash requested during a memory wait is applied later.
// Optional feature macro: PERF_COUNTERS_EN adds retired/stall/flush counters
// on the perf_cnt port.
module pipe_valid_ctrl
  import pipe_ctrl_pkg::*;
`ifdef PERF_COUNTERS_EN
#(
  parameter int CNT_W = 32
)
`endif
(
  input  logic       clk,
  input  logic       reset,
  input  logic       fetch_valid,
  input  logic       id_is_load,
  input  logic       stop_ID,
  input  logic       set_invalid_ID,
  input  logic       set_invalid_EX,
  input  logic       set_invalid_MEM,
  input  logic       set_invalid_WB,
  input  logic       mem_busy,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       id_ex_en,
  output logic       ex_mem_en,
  output logic       ID_invalid,
  output logic       EX_invalid,
  output logic       MEM_invalid,
  output logic       WB_invalid,
  output logic       is_load_EX,
  output logic       is_load_MEM,
  output logic       retire,
  output logic [1:0] stall_cause
`ifdef PERF_COUNTERS_EN
  ,
  output logic [3*CNT_W-1:0] perf_cnt
`endif
);

  logic                  vId_q, vEx_q, vMem_q, vWb_q;
  logic                  vId_d, vEx_d, vMem_d, vWb_d;
  logic                  isLoadEx_q, isLoadMem_q;
  logic                  isLoadEx_d, isLoadMem_d;
  logic                  flushPend_q, flushPend_d;
  logic [NUM_STAGES-1:0] flV_q, flV_d;
  logic                  retire_q;

  logic [NUM_STAGES-1:0] setVec;
  logic [NUM_STAGES-1:0] flMask;
  logic                  memWait;
  logic                  flushReq;
  stall_cause_e          cause;

  assign setVec[STG_ID]  = set_invalid_ID;
  assign setVec[STG_EX]  = set_invalid_EX;
  assign setVec[STG_MEM] = set_invalid_MEM;
  assign setVec[STG_WB]  = set_invalid_WB;

  // A busy memory only matters when MEM actually holds an instruction
  assign memWait  = mem_busy & vMem_q;
  assign flushReq = (|setVec) | flushPend_q;
  assign flMask   = setVec | flV_q;
  assign cause    = encodeCause(memWait, flushReq, stop_ID);

  // Next-state for valid bits, load tags and the deferred-flush bookkeeping
  always_comb begin
    vId_d       = vId_q;
    vEx_d       = vEx_q;
    vMem_d      = vMem_q;
    vWb_d       = vWb_q;
    isLoadEx_d  = isLoadEx_q;
    isLoadMem_d = isLoadMem_q;
    flushPend_d = flushPend_q;
    flV_d       = flV_q;
    unique case (cause)
      CAUSE_MEM_WAIT: begin
        vWb_d       = 1'b0;
        flV_d       = flV_q | setVec;
        flushPend_d = flushPend_q | (|setVec);
      end
      CAUSE_FLUSH: begin
        vId_d       = fetch_valid & ~flMask[STG_ID];
        vEx_d       = vId_q  & ~flMask[STG_EX];
        vMem_d      = vEx_q  & ~flMask[STG_MEM];
        vWb_d       = vMem_q & ~flMask[STG_WB];
        isLoadEx_d  = id_is_load & vId_q & ~flMask[STG_EX];
        isLoadMem_d = isLoadEx_q & vEx_q & ~flMask[STG_MEM];
        flushPend_d = 1'b0;
        flV_d       = '0;
      end
      CAUSE_LOAD_USE: begin
        vEx_d       = 1'b0;
        vMem_d      = vEx_q;
        vWb_d       = vMem_q;
        isLoadEx_d  = 1'b0;
        isLoadMem_d = isLoadEx_q;
      end
      default: begin
        vId_d       = fetch_valid;
        vEx_d       = vId_q;
        vMem_d      = vEx_q;
        vWb_d       = vMem_q;
        isLoadEx_d  = id_is_load & vId_q;
        isLoadMem_d = isLoadEx_q & vEx_q;
      end
    endcase
  end

  // Pipeline control state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vId_q       <= 1'b0;
      vEx_q       <= 1'b0;
      vMem_q      <= 1'b0;
      vWb_q       <= 1'b0;
      isLoadEx_q  <= 1'b0;
      isLoadMem_q <= 1'b0;
      flushPend_q <= 1'b0;
      flV_q       <= '0;
      retire_q    <= 1'b0;
    end else begin
      vId_q       <= vId_d;
      vEx_q       <= vEx_d;
      vMem_q      <= vMem_d;
      vWb_q       <= vWb_d;
      isLoadEx_q  <= isLoadEx_d;
      isLoadMem_q <= isLoadMem_d;
      flushPend_q <= flushPend_d;
      flV_q       <= flV_d;
      retire_q    <= vWb_q;
    end
  end

  // Register enables and cause output; everything is held off during reset
  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_en    = 1'b0;
    ex_mem_en   = 1'b0;
    stall_cause = CAUSE_NONE;
    if (!reset) begin
      stall_cause = cause;
      unique case (cause)
        CAUSE_MEM_WAIT: ;
        CAUSE_LOAD_USE: ex_mem_en = 1'b1;
        default: begin
          pc_en     = 1'b1;
          if_id_en  = 1'b1;
          id_ex_en  = 1'b1;
          ex_mem_en = 1'b1;
        end
      endcase
    end
  end

  assign ID_invalid  = ~vId_q;
  assign EX_invalid  = ~vEx_q;
  assign MEM_invalid = ~vMem_q;
  assign WB_invalid  = ~vWb_q;
  assign is_load_EX  = isLoadEx_q;
  assign is_load_MEM = isLoadMem_q;
  assign retire      = retire_q;

`ifdef PERF_COUNTERS_EN
  logic [CNT_W-1:0] cntRetired, cntStall, cntFlush;
  logic             stallEvent, flushEvent;

  // A flush is counted only in the cycle it is applied, not while pending
  assign stallEvent = (cause == CAUSE_LOAD_USE) || (cause == CAUSE_MEM_WAIT);
  assign flushEvent = (cause == CAUSE_FLUSH);

  perf_counter #(.CNT_W(CNT_W)) u_cntRetired (
    .clk   (clk),
    .reset (reset),
    .inc   (retire_q),
    .q     (cntRetired)
  );

  perf_counter #(.CNT_W(CNT_W)) u_cntStall (
    .clk   (clk),
    .reset (reset),
    .inc   (stallEvent),
    .q     (cntStall)
  );

  perf_counter #(.CNT_W(CNT_W)) u_cntFlush (
    .clk   (clk),
    .reset (reset),
    .inc   (flushEvent),
    .q     (cntFlush)
  );

  assign perf_cnt = {cntRetired, cntStall, cntFlush};
`endif

endmodule
